// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_buffer
//  Purpose  : I-cache to decoder byte queue. Fetches aligned chunks, presents
//             a 15-byte window at decode_rip and pops consumed bytes.
//  Revision : 1.0
// ============================================================================
module fetch_buffer #(
    parameter int BUF_BYTES  = 32,
    parameter int FILL_BYTES = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [63:0]  entry,
    input  logic         set_rip,
    input  logic [63:0]  new_rip,
    output logic         icache_enable,
    output logic [63:0]  icache_addr,
    input  logic [511:0] icache_rdata,
    input  logic         icache_done,
    output logic [0:119] decode_bytes,
    output logic [63:0]  decode_rip,
    output logic         decode_valid,
    input  logic         decode_take,
    input  logic [7:0]   bytes_decoded
);

    localparam int CNT_W = $clog2(BUF_BYTES + 1);
    localparam int c_win_bytes = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         buf_q [BUF_BYTES];
    logic [7:0]         buf_d [BUF_BYTES];
    logic [63:0]        fetch_pc_q, fetch_pc_d;
    logic [63:0]        decode_rip_q, decode_rip_d;
    logic               icache_enable_q, icache_enable_d;
    logic [63:0]        icache_addr_q, icache_addr_d;
    logic               decode_valid_q, decode_valid_d;
    logic [0:119]       decode_bytes_q, decode_bytes_d;

    logic               w_pop_ok;
    logic [CNT_W-1:0]   w_pop_cnt;
    logic [CNT_W-1:0]   w_tail;
    logic [CNT_W-1:0]   w_free;
    logic [6:0]         w_off;
    logic [6:0]         w_fill_n;
    logic               w_fill;
    logic [5:0]         w_line_idx;
    logic [7:0]         w_ext [BUF_BYTES + 15];
    int                 w_idx;

    always_comb begin
        w_pop_ok  = decode_take && decode_valid_q &&
                    (bytes_decoded != 8'd0) && (bytes_decoded <= 8'd15);
        w_pop_cnt = w_pop_ok ? CNT_W'(bytes_decoded) : '0;
        w_tail    = count_q - w_pop_cnt;
        w_free    = CNT_W'(BUF_BYTES) - count_q;
        w_off     = {1'b0, fetch_pc_q[5:0] & 6'(FILL_BYTES - 1)};
        w_fill_n  = 7'(FILL_BYTES) - w_off;
        w_fill    = icache_done && (state_q == FETCH);
    end

    // Bytes at and beyond count are kept at zero, so the window needs no mask.
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        fetch_pc_d      = fetch_pc_q;
        decode_rip_d    = decode_rip_q;
        icache_enable_d = icache_enable_q;
        icache_addr_d   = icache_addr_q;
        w_line_idx      = '0;
        w_idx           = 0;

        for (int i = 0; i < BUF_BYTES; i++) begin
            w_ext[i] = buf_q[i];
        end
        for (int i = BUF_BYTES; i < BUF_BYTES + 15; i++) begin
            w_ext[i] = 8'h00;
        end
        for (int i = 0; i < BUF_BYTES; i++) begin
            buf_d[i] = w_ext[i + int'(w_pop_cnt)];
        end

        if (set_rip) begin
            count_d      = '0;
            fetch_pc_d   = new_rip;
            decode_rip_d = new_rip;
            for (int i = 0; i < BUF_BYTES; i++) begin
                buf_d[i] = 8'h00;
            end
            // An in-flight request must still be completed by the I-cache.
            if ((state_q == FETCH || state_q == DISCARD) && !icache_done) begin
                state_d = DISCARD;
            end else begin
                state_d         = IDLE;
                icache_enable_d = 1'b0;
            end
        end else begin
            decode_rip_d = decode_rip_q + 64'(w_pop_cnt);
            count_d      = w_tail;

            if (w_fill) begin
                for (int j = 0; j < FILL_BYTES; j++) begin
                    if (7'(j) < w_fill_n) begin
                        w_idx      = int'(w_tail) + j;
                        w_line_idx = icache_addr_q[5:0] + w_off[5:0] + 6'(j);
                        if (w_idx < BUF_BYTES) begin
                            buf_d[w_idx] = icache_rdata[{w_line_idx, 3'b000} +: 8];
                        end
                    end
                end
                count_d = w_tail + CNT_W'(w_fill_n);
            end

            case (state_q)
                IDLE: begin
                    if (int'(w_free) >= FILL_BYTES) begin
                        state_d         = FETCH;
                        icache_enable_d = 1'b1;
                        icache_addr_d   = fetch_pc_q & ~64'(FILL_BYTES - 1);
                    end
                end
                FETCH: begin
                    if (icache_done) begin
                        state_d         = IDLE;
                        icache_enable_d = 1'b0;
                        fetch_pc_d      = fetch_pc_q + 64'(w_fill_n);
                    end
                end
                DISCARD: begin
                    if (icache_done) begin
                        state_d         = IDLE;
                        icache_enable_d = 1'b0;
                    end
                end
                default: begin
                    state_d         = IDLE;
                    icache_enable_d = 1'b0;
                end
            endcase
        end

        decode_valid_d = (int'(count_d) >= c_win_bytes);
        decode_bytes_d = '0;
        for (int k = 0; k < c_win_bytes; k++) begin
            decode_bytes_d[8*k +: 8] = buf_d[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            count_q         <= '0;
            buf_q           <= '{default: 8'h00};
            fetch_pc_q      <= entry;
            decode_rip_q    <= entry;
            icache_enable_q <= 1'b0;
            icache_addr_q   <= '0;
            decode_valid_q  <= 1'b0;
            decode_bytes_q  <= '0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            buf_q           <= buf_d;
            fetch_pc_q      <= fetch_pc_d;
            decode_rip_q    <= decode_rip_d;
            icache_enable_q <= icache_enable_d;
            icache_addr_q   <= icache_addr_d;
            decode_valid_q  <= decode_valid_d;
            decode_bytes_q  <= decode_bytes_d;
        end
    end

    assign icache_enable = icache_enable_q;
    assign icache_addr   = icache_addr_q;
    assign decode_rip    = decode_rip_q;
    assign decode_valid  = decode_valid_q;
    assign decode_bytes  = decode_bytes_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_buffer
//  Purpose  : Directed self-checking bench for fetch_buffer.
//  Revision : 1.0
// ============================================================================
module tb_fetch_buffer;

    logic         clk;
    logic         reset_n;
    logic [63:0]  entry;
    logic         set_rip;
    logic [63:0]  new_rip;
    logic         icache_enable;
    logic [63:0]  icache_addr;
    logic [511:0] icache_rdata;
    logic         icache_done;
    logic [0:119] decode_bytes;
    logic [63:0]  decode_rip;
    logic         decode_valid;
    logic         decode_take;
    logic [7:0]   bytes_decoded;

    int n_vec = 0;
    int n_err = 0;

    fetch_buffer #(.BUF_BYTES(32), .FILL_BYTES(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .entry         (entry),
        .set_rip       (set_rip),
        .new_rip       (new_rip),
        .icache_enable (icache_enable),
        .icache_addr   (icache_addr),
        .icache_rdata  (icache_rdata),
        .icache_done   (icache_done),
        .decode_bytes  (decode_bytes),
        .decode_rip    (decode_rip),
        .decode_valid  (decode_valid),
        .decode_take   (decode_take),
        .bytes_decoded (bytes_decoded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        icache_done = 1'b1;
        tick();
        icache_done = 1'b0;
    endtask

    task automatic line_pattern();
        for (int k = 0; k < 64; k++) icache_rdata[8*k +: 8] = 8'(k);
    endtask

    // Expected window: cnt consecutive byte values from start, zeros after.
    function automatic logic [0:119] win(input logic [7:0] start, input int cnt);
        logic [0:119] w;
        w = '0;
        for (int k = 0; k < 15; k++) begin
            if (k < cnt) w[8*k +: 8] = start + 8'(k);
        end
        return w;
    endfunction

    initial begin
        reset_n = 1'b0; entry = 64'h40_0000; set_rip = 1'b0; new_rip = '0;
        icache_done = 1'b0; decode_take = 1'b0; bytes_decoded = '0;
        line_pattern();

        // Reset state and first fill
        tick(); tick();
        check_value("rst_en",    128'(icache_enable), 128'(0));
        check_value("rst_addr",  128'(icache_addr),   128'(0));
        check_value("rst_valid", 128'(decode_valid),  128'(0));
        check_value("rst_bytes", 128'(decode_bytes),  128'(0));
        check_value("rst_rip",   128'(decode_rip),    128'(64'h40_0000));
        reset_n = 1'b1;
        tick();
        check_value("t1_en",   128'(icache_enable), 128'(1));
        check_value("t1_addr", 128'(icache_addr),   128'(64'h40_0000));
        tick(); tick();
        check_value("t1_hold", 128'(icache_enable), 128'(1));
        pulse_done();
        check_value("t1_valid", 128'(decode_valid),  128'(1));
        check_value("t1_win",   128'(decode_bytes),  128'(win(8'h00, 15)));
        check_value("t1_rip",   128'(decode_rip),    128'(64'h40_0000));
        check_value("t1_endone",128'(icache_enable), 128'(0));

        // Pop 3 while the next request issues
        decode_take = 1'b1; bytes_decoded = 8'd3;
        tick();
        decode_take = 1'b0;
        check_value("t2_rip",   128'(decode_rip),   128'(64'h40_0003));
        check_value("t2_valid", 128'(decode_valid), 128'(0));
        check_value("t2_win",   128'(decode_bytes), 128'(win(8'h03, 13)));
        check_value("t2_addr",  128'(icache_addr),  128'(64'h40_0010));
        pulse_done();
        check_value("t2_valid2", 128'(decode_valid), 128'(1));
        check_value("t2_win2",   128'(decode_bytes), 128'(win(8'h03, 15)));

        // Unaligned entry
        reset_n = 1'b0; entry = 64'h40_000E;
        tick();
        reset_n = 1'b1;
        tick();
        check_value("t3_addr", 128'(icache_addr), 128'(64'h40_0000));
        pulse_done();
        check_value("t3_valid", 128'(decode_valid), 128'(0));
        check_value("t3_win",   128'(decode_bytes), 128'(win(8'h0E, 2)));
        tick();
        check_value("t3_addr2", 128'(icache_addr), 128'(64'h40_0010));
        pulse_done();
        check_value("t3_valid2", 128'(decode_valid), 128'(1));
        check_value("t3_win2",   128'(decode_bytes), 128'(win(8'h0E, 15)));
        check_value("t3_rip",    128'(decode_rip),   128'(64'h40_000E));

        // Redirect while a request is pending
        reset_n = 1'b0; entry = 64'h40_0000;
        tick();
        reset_n = 1'b1;
        tick();
        set_rip = 1'b1; new_rip = 64'h50_0000;
        tick();
        set_rip = 1'b0;
        check_value("t4_en",    128'(icache_enable), 128'(1));
        check_value("t4_addr",  128'(icache_addr),   128'(64'h40_0000));
        check_value("t4_rip",   128'(decode_rip),    128'(64'h50_0000));
        check_value("t4_valid", 128'(decode_valid),  128'(0));
        icache_rdata = {512{1'b1}};
        pulse_done();
        check_value("t4_en2",   128'(icache_enable), 128'(0));
        check_value("t4_bytes", 128'(decode_bytes),  128'(0));
        tick();
        check_value("t4_addr2", 128'(icache_addr), 128'(64'h50_0000));
        line_pattern();
        pulse_done();
        check_value("t4_valid2", 128'(decode_valid), 128'(1));
        check_value("t4_win",    128'(decode_bytes), 128'(win(8'h00, 15)));

        // Pop 15 coinciding with a fill at count 16
        tick();
        check_value("t5_addr", 128'(icache_addr), 128'(64'h50_0010));
        decode_take = 1'b1; bytes_decoded = 8'd15; icache_done = 1'b1;
        tick();
        decode_take = 1'b0; icache_done = 1'b0;
        check_value("t5_rip",   128'(decode_rip),   128'(64'h50_000F));
        check_value("t5_win",   128'(decode_bytes), 128'(win(8'h0F, 15)));
        check_value("t5_valid", 128'(decode_valid), 128'(1));
        decode_take = 1'b1; bytes_decoded = 8'd3;
        tick();
        decode_take = 1'b0;
        check_value("t5_valid2", 128'(decode_valid), 128'(0));
        check_value("t5_win2",   128'(decode_bytes), 128'(win(8'h12, 14)));
        tick();
        check_value("t5_en",    128'(icache_enable), 128'(1));
        check_value("t5_addr2", 128'(icache_addr),   128'(64'h50_0020));

        // Reset mid-fetch; takes ignored while invalid or out of range
        reset_n = 1'b0; entry = 64'h60_0000;
        tick();
        check_value("t6_en",   128'(icache_enable), 128'(0));
        check_value("t6_addr", 128'(icache_addr),   128'(0));
        check_value("t6_rip",  128'(decode_rip),    128'(64'h60_0000));
        reset_n = 1'b1; decode_take = 1'b1; bytes_decoded = 8'd5;
        tick();
        check_value("t6_rip2", 128'(decode_rip),  128'(64'h60_0000));
        check_value("t6_addr2",128'(icache_addr), 128'(64'h60_0000));
        pulse_done();
        check_value("t6_rip3", 128'(decode_rip),   128'(64'h60_0000));
        check_value("t6_win",  128'(decode_bytes), 128'(win(8'h00, 15)));
        bytes_decoded = 8'd0;
        tick();
        check_value("t6_zero", 128'(decode_rip), 128'(64'h60_0000));
        bytes_decoded = 8'd16;
        tick();
        decode_take = 1'b0;
        check_value("t6_big", 128'(decode_rip), 128'(64'h60_0000));

        // Redirect near the top of the address space; fetch_pc wraps
        set_rip = 1'b1; new_rip = 64'hFFFF_FFFF_FFFF_FFF0;
        tick();
        set_rip = 1'b0;
        check_value("t7_rip", 128'(decode_rip), 128'(64'hFFFF_FFFF_FFFF_FFF0));
        pulse_done();
        tick();
        check_value("t7_addr", 128'(icache_addr), 128'(64'hFFFF_FFFF_FFFF_FFF0));
        pulse_done();
        check_value("t7_win", 128'(decode_bytes), 128'(win(8'h30, 15)));
        tick();
        check_value("t7_wrap", 128'(icache_addr), 128'(64'h0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
